// File: rtl/step_clock_ctrl_pkg.sv
// Shared encodings for the processor stepping controller.
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_STOP = 2'b00,
    MODE_SLOW = 2'b01,
    MODE_FAST = 2'b10,
    MODE_STEP = 2'b11
  } mode_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

endpackage

// File: rtl/step_clock_ctrl_sync_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer with a
// registered one-cycle rise pulse.
module sync_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = ~level_q;
        rise_d  = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/step_clock_ctrl.sv
// Processor stepping controller: produces a one-cycle step_en clock-enable
// from the selected run mode, with halt capture and an enter handshake.
module step_clock_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int TICK_HZ      = 2,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             step_btn,
  input  logic             enter_sw,
  input  logic             halt,
  output logic             step_en,
  output logic             enter_req,
  output logic             heartbeat,
  output logic             halted,
  output logic [CNT_W-1:0] step_count
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

  logic             step_level, step_rise;
  logic             enter_level, enter_rise;
  logic [DW-1:0]    div_q, div_d;
  logic             tick;
  logic             qual;
  state_e           state_q, state_d;
  logic             step_en_q, step_en_d;
  logic             enter_req_q, enter_req_d;
  logic             heartbeat_q, heartbeat_d;
  logic [CNT_W-1:0] step_count_q, step_count_d;

  sync_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_step_db (
    .clock (clock),
    .reset (reset),
    .raw   (step_btn),
    .level (step_level),
    .rise  (step_rise)
  );

  sync_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_enter_db (
    .clock (clock),
    .reset (reset),
    .raw   (enter_sw),
    .level (enter_level),
    .rise  (enter_rise)
  );

  // Divider free-runs regardless of mode so SLOW cadence never restarts.
  assign tick  = (div_q == DIV_MAX);
  assign div_d = tick ? '0 : div_q + DW'(1);

  always_comb begin
    unique case (mode_e'(mode))
      MODE_STOP: qual = 1'b0;
      MODE_SLOW: qual = tick;
      MODE_FAST: qual = 1'b1;
      MODE_STEP: qual = step_rise;
      default:   qual = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    step_en_d = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        step_en_d = qual & ~halt;
        if (halt) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (mode_e'(mode) == MODE_STOP) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    heartbeat_d  = heartbeat_q ^ step_en_q;
    step_count_d = step_en_q ? step_count_q + CNT_W'(1) : step_count_q;
    // A fresh rise takes priority over consumption so no request is lost.
    enter_req_d  = enter_req_q;
    if (enter_rise)     enter_req_d = 1'b1;
    else if (step_en_q) enter_req_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q        <= '0;
      state_q      <= ST_RUN;
      step_en_q    <= 1'b0;
      enter_req_q  <= 1'b0;
      heartbeat_q  <= 1'b0;
      step_count_q <= '0;
    end else begin
      div_q        <= div_d;
      state_q      <= state_d;
      step_en_q    <= step_en_d;
      enter_req_q  <= enter_req_d;
      heartbeat_q  <= heartbeat_d;
      step_count_q <= step_count_d;
    end
  end

  assign step_en    = step_en_q;
  assign enter_req  = enter_req_q;
  assign heartbeat  = heartbeat_q;
  assign halted     = (state_q == ST_HALTED);
  assign step_count = step_count_q;

endmodule

// File: doc/step_clock_ctrl.md
Name: step_clock_ctrl

Overview:
- Parametrised processor-stepping controller for the board-level top; successor to the fixed half-second clock divider.
- Runs entirely on the 50 MHz board clock and emits a one-cycle `step_en` clock-enable, which the datapath and control unit qualify their registers with.
- Adds run modes (stop / slow / fast / single-step), halt capture, synchronised and debounced step button and enter switch, an enter request held until consumed, and a step counter.

Parameters:
- CLK_HZ, 50000000, board clock frequency.
- TICK_HZ, 2, slow-mode step rate. Localparam DIV = CLK_HZ/TICK_HZ; DIV >= 2 is required.
- DEBOUNCE_CYC, 500000, consecutive stable cycles before a debounced level changes. Must be >= 1.
- CNT_W, 16, width of step_count.

Ports:
- clock, input, 1, board clock (CLOCK_50).
- reset, input, 1, synchronous, active-high.
- mode, input, 2, run mode: 00 STOP, 01 SLOW, 10 FAST, 11 STEP.
- step_btn, input, 1, raw asynchronous step button, active-high.
- enter_sw, input, 1, raw asynchronous enter switch.
- halt, input, 1, halt flag from the control unit.
- step_en, output, 1, one-cycle processor clock-enable.
- enter_req, output, 1, enter request, held until consumed.
- heartbeat, output, 1, toggles on every step_en (drives LEDG[7]).
- halted, output, 1, high in the HALTED state.
- step_count, output, CNT_W, number of steps issued; wraps.

Behaviour:
- Reset: one clock and reset domain; reset is synchronous and active-high. All outputs, counters, synchronisers and debounce levels reset to 0. FSM resets to RUN.
- Sync: step_btn and enter_sw each pass through a 2-FF synchroniser.
- Debounce:
  - A counter counts while the synced input differs from the debounced level; it clears whenever they match.
  - When the counter reaches DEBOUNCE_CYC-1 while they still differ, the level flips and the counter clears.
  - A rise is detected when the debounced level goes 0->1 (one cycle).
- Divider: free-running counter 0..DIV-1 that wraps to 0. `tick` is high in the cycle where the count equals DIV-1. The divider runs in every mode and is never reset by a mode change.
- Qualifying event, by mode:
  - STOP: never.
  - SLOW: tick.
  - FAST: every cycle.
  - STEP: debounced step_btn rise.
- FSM:
  - RUN: step_en is registered, high in the cycle after a qualifying event. If halt is high, go to HALTED; the next cycle has no step_en, even if a qualifying event occurs in the same cycle.
  - HALTED: step_en stays 0 and halted = 1. Exit to RUN only when mode == STOP for at least one cycle, or on reset.
- Step side effects: on each step_en cycle, heartbeat toggles and step_count increments, wrapping from 2^CNT_W-1 to 0.
- enter_req handshake:
  - Set on a debounced enter_sw rise.
  - Cleared on the clock edge that ends a step_en=1 cycle, so the control unit samples it exactly once.
  - A rise in the same cycle as step_en keeps enter_req set (set wins).
  - Further rises while already set are absorbed.
- Mode change mid-operation takes effect on the next cycle. A pending STEP edge is not remembered across mode changes.

Decomposition:
- Package step_ctrl_pkg:
  - mode encodings MODE_STOP, MODE_SLOW, MODE_FAST, MODE_STEP;
  - FSM state encodings ST_RUN, ST_HALTED.
- Sub-module sync_debounce:
  - parameter DEBOUNCE_CYC; ports clock, reset, raw, level, rise;
  - instantiated twice.

Test Plan (CLK_HZ=20, TICK_HZ=2 so DIV=10; DEBOUNCE_CYC=4; CNT_W=4):
- Reset then SLOW for 50 cycles -> step_en pulses exactly every 10 cycles, one cycle wide; step_count=5; heartbeat=1.
- FAST with halt raised at cycle 7 -> step_en high every cycle through the cycle of the halt sample, then 0; halted=1. STOP 1 cycle then FAST -> halted=0 and stepping resumes.
- STEP mode, step_btn glitch 2 cycles high -> no step_en. Hold high 10 cycles -> exactly one step_en, 2 sync + 4 debounce + 1 register cycles after the press.
- enter_sw held high (debounced) in STOP -> enter_req rises and stays high. Switch to FAST -> enter_req clears after the first step_en cycle.
- FAST for 17 cycles with CNT_W=4 -> step_count wraps 15->0->1.
- Assert reset mid-SLOW, with a half-counted divider and enter_req=1 -> all outputs 0 the next cycle, and the first step_en comes 10 cycles after reset is released.
